// File: rtl/alu_share_arbiter_if.sv
// Bundles the requester command/response bus and the ALU-facing lines of the shared-ALU arbiter.
// The arbiter plugs in as slave; the client/ALU side plugs in as master.
interface alu_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [3*NREQ-1:0] req_op;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_result;
    logic              rsp_err;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [2:0]        alu_op;
    logic              alu_start;
    logic              alu_rst_n;
    logic              alu_done;
    logic [15:0]       alu_result;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_done, alu_result,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
               alu_a, alu_b, alu_op, alu_start, alu_rst_n
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_done, alu_result,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
               alu_a, alu_b, alu_op, alu_start, alu_rst_n
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one start/done ALU among NREQ requesters, with a done watchdog
// that pulses the ALU reset and answers the stuck command with an error response.
module alu_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RECOVER, RESP} state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b100;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d;
    logic [7:0]     a_q, a_d, b_q, b_d;
    logic [2:0]     op_q, op_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           rcnt_q, rcnt_d;
    logic [15:0]    res_q, res_d;
    logic           err_q, err_d;
    logic           alu_rst_n_q;

    logic [IDW-1:0]  win, cand;
    logic            win_vld;
    logic [7:0]      win_a, win_b;
    logic [2:0]      win_op;
    logic [NREQ-1:0] ready;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win     = '0;
        cand    = '0;
        win_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!win_vld && bus.req_valid[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
        win_a  = bus.req_a[int'(win)*8 +: 8];
        win_b  = bus.req_b[int'(win)*8 +: 8];
        win_op = bus.req_op[int'(win)*3 +: 3];
    end

    always_comb begin
        ready = '0;
        if (state_q == IDLE && win_vld) ready[win] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    ptr_d = win;
                    id_d  = win;
                    a_d   = win_a;
                    b_d   = win_b;
                    op_d  = win_op;
                    cnt_d = '0;
                    if (win_op == OP_NOP || win_op > OP_MUL) begin
                        state_d = RESP;
                        res_d   = '0;
                        err_d   = (win_op > OP_MUL);
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // The watchdog is checked first so a done on the expiry edge is discarded.
                if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = RECOVER;
                    rcnt_d  = 1'b0;
                end else if (bus.alu_done) begin
                    state_d = RESP;
                    res_d   = bus.alu_result;
                    err_d   = 1'b0;
                end
            end
            RECOVER: begin
                if (rcnt_q) begin
                    state_d = RESP;
                    res_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    rcnt_d = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            rcnt_q      <= 1'b0;
            res_q       <= '0;
            err_q       <= 1'b0;
            alu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            res_q       <= res_d;
            err_q       <= err_d;
            alu_rst_n_q <= (state_d != RECOVER);
        end
    end

    assign bus.req_ready  = ready;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_err    = err_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_start  = (state_q == BUSY);
    assign bus.alu_rst_n  = alu_rst_n_q;
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one ALU (8-bit operands A/B, 3-bit op, start/done handshake, 16-bit result) among NREQ requesters. It accepts one command at a time over per-requester valid/ready ports and drives the ALU start/op/A/B lines. It waits for done and returns the result, tagged with the requester ID, on a shared response bus. A watchdog recovers a hung ALU by pulsing its reset. It sits between the command-generating clients and the ALU instance.

## Interface
- NREQ, 4, number of requesters (2..8); IDW = $clog2(NREQ)
- TIMEOUT, 32, max BUSY cycles waiting for alu_done before abort (2..255)
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_a  in  8*NREQ  operand A, requester i at [8i+7:8i]
- req_b  in  8*NREQ  operand B, same packing
- req_op  in  3*NREQ  opcode, requester i at [3i+2:3i]
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  IDW  requester index of response
- rsp_result  out  16  ALU result, or 0 on error/no_op
- rsp_err  out  1  1 = invalid opcode or timeout
- alu_a, alu_b  out  8  registered operands to ALU
- alu_op  out  3  registered opcode to ALU
- alu_start  out  1  ALU start, held until done sampled
- alu_rst_n  out  1  ALU reset, low during recovery
- alu_done  in  1  ALU completion
- alu_result  in  16  ALU result, valid when alu_done=1

## Operation
- Opcodes: 000 no_op, 001 add, 010 and, 011 xor, 100 mul; 101/110/111 are invalid.
- FSM states: IDLE, BUSY, RECOVER, RESP.
- IDLE
  - Round-robin winner = first requester with req_valid=1, searching from ptr+1 mod NREQ upward.
  - req_ready[winner]=1 combinationally, only in IDLE; all other bits 0.
  - On handshake, capture a/b/op/id and set ptr=winner. ptr is unchanged when no handshake occurs.
  - Next state after handshake: valid non-no_op goes to BUSY; no_op or invalid goes to RESP.
- BUSY
  - alu_start=1; alu_a/b/op are held from the captured values; the timeout counter increments each cycle.
  - alu_done=1 sampled: capture alu_result, set err=0, drop alu_start, go to RESP.
  - Counter reaches TIMEOUT with no done: drop alu_start, go to RECOVER. Timeout wins if done arrives on the same edge the counter hits TIMEOUT.
- RECOVER
  - alu_rst_n=0 for exactly 2 cycles, alu_start=0.
  - Then go to RESP with err=1, result=0.
- RESP
  - rsp_valid=1 for one cycle, with rsp_id, rsp_result and rsp_err.
  - There is no backpressure; the response must be consumed that cycle.
  - Always returns to IDLE.
- no_op responses: err=0, result=0. Invalid-op responses: err=1, result=0. Neither asserts alu_start.
- Results pass through unmodified, 16 bits wide; there is no arithmetic in this block.
- Asynchronous reset, applied at any time including mid-operation:
  - Outputs: state=IDLE, ptr=NREQ-1 (requester 0 first), req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, alu_a/b/op=0, alu_start=0, alu_rst_n=0 while rst_n=0.
  - alu_rst_n returns to 1 on the first clk after release.
  - The in-flight command is dropped and no response is issued for it.
- Requesters must hold req_valid and their operands stable until ready. Dropping valid before grant is legal; that requester simply loses its turn.

## Timing
- Handshake at edge T0: alu_start is high from cycle T0+1.
- alu_done sampled high at edge Tn: alu_start is low and rsp_valid is high in cycle Tn+1.
- IDLE is re-entered at Tn+2. The earliest next handshake is at edge Tn+2.
- Single-cycle ALU op (done one cycle after start): 4 cycles from handshake edge to the next handshake edge.
- no_op or invalid op: handshake at T0, rsp_valid in cycle T0+1, IDLE at T0+2.
- Timeout:
  - alu_start is high for TIMEOUT cycles.
  - alu_rst_n is low for the next 2 cycles.
  - rsp_valid (err=1) follows, then IDLE.
- alu_done while not in BUSY is ignored.

## Test plan
- Req0 a=8'h12 b=8'h34 op=001 -> alu_a/b/op match from T0+1; ALU done -> rsp_id=0, rsp_result=16'h0046, rsp_err=0, single-cycle strobe.
- Req2 mul a=8'hFF b=8'hFF, ALU done after 3 cycles -> alu_start high exactly 3 cycles, rsp_id=2, rsp_result=16'hFE01.
- All 4 requesters valid continuously after reset -> grant order 0,1,2,3,0,1; no requester granted twice before the others; at most one req_ready bit set.
- ALU model never asserts done, TIMEOUT=32 -> alu_start high 32 cycles, alu_rst_n low 2 cycles, rsp_err=1, rsp_result=0; the next command completes normally.
- Req1 op=111 then req1 op=000 -> no alu_start for either; responses one cycle after each handshake, err=1 then err=0, result=0 both.
- rst_n low mid-mul (BUSY cycle 2) -> all outputs at reset values immediately, no response; after release req3 and req0 both valid -> req0 granted first.
